// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//   Sequencer for an iterative radix-2 restoring divider that serves the
//   DIV/DIVU instructions. An accepted start latches the operand magnitudes and
//   the sign flags. The block then runs WIDTH shift/trial-subtract steps, applies
//   the sign fix-up and presents quotient/remainder for one cycle with ready_o.
//   While the operation is accepted or iterating, stall_o holds the front of the
//   pipeline.
//
// Optional feature macro: DIV_ZERO_FAST_EN
//   defined   : a zero divisor goes IDLE -> DONE directly (result one cycle later)
//   undefined : a zero divisor runs the full WIDTH iterations
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   start_i   in   DIV/DIVU present in execute, operands valid
//   signed_i  in   1 = DIV (two's complement), 0 = DIVU
//   annul_i   in   cancel in-flight / pending division
//   a_i, b_i  in   dividend, divisor
//   stall_o   out  hold F/D/E stages
//   busy_o    out  iterating
//   ready_o   out  one-cycle pulse, hi_o/lo_o carry a new result
//   hi_o      out  remainder
//   lo_o      out  quotient
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's complement negate when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   shifted_s;
    logic             ge_s;
    logic [WIDTH-1:0] sub_s;
    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_quo_s;
    logic             accept_s;

    // Next-state logic: one restoring step per BUSY cycle plus FSM sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_raw_d = a_raw_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        ready_d = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        accept_s = start_i & ~annul_i;

        // Trial subtract. The compare is done WIDTH+1 wide. Because rem < divisor
        // holds throughout, the difference always fits WIDTH bits, so a WIDTH-bit
        // modular subtract is exact when it is used.
        shifted_s  = {rem_q, quo_q[WIDTH-1]};
        ge_s       = (shifted_s >= {1'b0, dvs_q});
        sub_s      = shifted_s[WIDTH-1:0] - dvs_q;
        step_rem_s = ge_s ? sub_s : shifted_s[WIDTH-1:0];
        step_quo_s = {quo_q[WIDTH-2:0], ge_s};

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    rem_d   = {WIDTH{1'b0}};
                    quo_d   = cond_neg(a_i, signed_i & a_i[WIDTH-1]);
                    dvs_d   = cond_neg(b_i, signed_i & b_i[WIDTH-1]);
                    a_raw_d = a_i;
                    q_neg_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    r_neg_d = signed_i & a_i[WIDTH-1];
                    dz_d    = (b_i == {WIDTH{1'b0}});
                    cnt_d   = {CNT_W{1'b0}};
`ifdef DIV_ZERO_FAST_EN
                    if (b_i == {WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                        lo_d    = {WIDTH{1'b1}};
                        hi_d    = a_i;
                    end else begin
                        state_d = ST_BUSY;
                    end
`else
                    state_d = ST_BUSY;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (annul_i) begin
                    // Abandon silently; the result registers keep the last value.
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                        if (dz_q) begin
                            // Divide by zero reports the raw dividend, not a magnitude.
                            lo_d = {WIDTH{1'b1}};
                            hi_d = a_raw_q;
                        end else begin
                            lo_d = cond_neg(step_quo_s, q_neg_q);
                            hi_d = cond_neg(step_rem_s, r_neg_q);
                        end
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                // Result is already committed; annul and start are ignored here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            a_raw_q <= {WIDTH{1'b0}};
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ready_q <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_raw_q <= a_raw_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            ready_q <= ready_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // The stall must rise in the acceptance cycle itself, so it is combinational.
    // It is gated by reset so that all outputs read 0 while reset is asserted.
    assign stall_o = rst & (((state_q == ST_IDLE) & start_i & ~annul_i) |
                            (state_q == ST_BUSY));
    assign busy_o  = (state_q == ST_BUSY);
    assign ready_o = ready_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        stall_o;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          total;
    int          bad;
    logic [63:0] exp_q[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .annul_i  (annul_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .ready_o  (ready_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the divider results.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int          lat;
        int          stall_cnt;
        int          exp_lat;
        logic [63:0] e;
        exp_lat = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) exp_lat = 1;
`endif
        @(negedge clk);
        a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
        exp_q.push_back({exp_hi, exp_lo});
        #1;
        check_val("stall_accept", {63'd0, stall_o}, 64'd1);
        stall_cnt = 1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (ready_o !== 1'b1 && lat < 100) begin
            if (stall_o === 1'b1) stall_cnt++;
            @(negedge clk);
            lat++;
        end
        if (ready_o !== 1'b1) begin
            check_val("ready_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end else begin
            check_val("latency", 64'(lat), 64'(exp_lat));
            check_val("stall_cycles", 64'(stall_cnt), 64'(exp_lat));
            check_val("stall_in_done", {63'd0, stall_o}, 64'd0);
            e = exp_q.pop_front();
            check_val("lo", {32'd0, lo_o}, {32'd0, e[31:0]});
            check_val("hi", {32'd0, hi_o}, {32'd0, e[63:32]});
            last_lo = e[31:0];
            last_hi = e[63:32];
            @(negedge clk);
            check_val("ready_pulse", {63'd0, ready_o}, 64'd0);
            check_val("lo_hold", {32'd0, lo_o}, {32'd0, last_lo});
            check_val("hi_hold", {32'd0, hi_o}, {32'd0, last_hi});
        end
    endtask

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        int          lat;
        logic        seen;

        total = 0; bad = 0;
        rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        a_i = 32'd0; b_i = 32'd0;
        last_hi = 32'd0; last_lo = 32'd0;

        repeat (2) @(negedge clk);
        check_val("rst_busy", {63'd0, busy_o}, 64'd0);
        check_val("rst_stall", {63'd0, stall_o}, 64'd0);
        check_val("rst_ready", {63'd0, ready_o}, 64'd0);
        check_val("rst_lo", {32'd0, lo_o}, 64'd0);
        check_val("rst_hi", {32'd0, hi_o}, 64'd0);
        rst = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_div(32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        run_div(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234);
        run_div(32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00);

        // Annul at BUSY cycle 10: no result, prior result kept.
        @(negedge clk);
        a_i = 32'd50; b_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_val("annul_busy_before", {63'd0, busy_o}, 64'd1);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check_val("annul_busy_after", {63'd0, busy_o}, 64'd0);
        check_val("annul_stall_after", {63'd0, stall_o}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o === 1'b1) seen = 1'b1;
        end
        check_val("annul_no_ready", {63'd0, seen}, 64'd0);
        check_val("annul_lo_kept", {32'd0, lo_o}, {32'd0, last_lo});
        check_val("annul_hi_kept", {32'd0, hi_o}, {32'd0, last_hi});

        run_div(32'd9, 32'd4, 1'b0, 32'd2, 32'd1);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (rb == 32'd0) rb = 32'd3;
            rs = (i % 2 == 1);
            ref_div(ra, rb, rs, rq, rr);
            run_div(ra, rb, rs, rq, rr);
        end

        // Reset asserted mid-operation at BUSY cycle 20.
        @(negedge clk);
        a_i = 32'd200; b_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rst = 1'b0;
        #1;
        check_val("midrst_busy", {63'd0, busy_o}, 64'd0);
        check_val("midrst_stall", {63'd0, stall_o}, 64'd0);
        check_val("midrst_ready", {63'd0, ready_o}, 64'd0);
        check_val("midrst_lo", {32'd0, lo_o}, 64'd0);
        check_val("midrst_hi", {32'd0, hi_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
        end
        check_val("midrst_idle", {63'd0, seen}, 64'd0);

        // start and annul together in IDLE: nothing happens.
        @(negedge clk);
        a_i = 32'd77; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1; annul_i = 1'b1;
        #1;
        check_val("sa_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        check_val("sa_busy", {63'd0, busy_o}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
        end
        check_val("sa_no_op", {63'd0, seen}, 64'd0);
        check_val("sa_lo", {32'd0, lo_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
